// File: rtl/rr_pkg.sv
// Shared FSM state type and default sizing for the grant-locked beat multiplexer.
package rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } rr_state_e;

    localparam int RR_REQCNT = 5;
    localparam int RR_DWIDTH = 8;

endpackage

// File: rtl/rr_skid_buf.sv
// Two-entry {last, data} skid buffer: ring of two slots with push/pop and occupancy.
module rr_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_push;
    logic         do_pop;

    assign do_push = push_i && (cnt_q != 2'd2);
    assign do_pop  = pop_i  && (cnt_q != 2'd0);
    assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/rr_grant_mux.sv
// Locks onto one granted requester and forwards its packet through a 2-entry skid buffer.
// Optional idle-lock abort is compiled in with `define RR_GRANT_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no lock; accepts a valid in-range grant index
//   LOCK  | forwarding beats of requester sel_q until a last beat (or timeout)
module rr_grant_mux
    import rr_pkg::*;
#(
    parameter int REQCNT   = RR_REQCNT,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int DWIDTH   = RR_DWIDTH,
    parameter int TIMEOUT  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [REQWIDTH-1:0]      req_num_i,
    input  logic                     req_num_val_i,
    input  logic [REQCNT*DWIDTH-1:0] data_i,
    input  logic [REQCNT-1:0]        data_val_i,
    input  logic [REQCNT-1:0]        data_last_i,
    output logic [REQCNT-1:0]        data_rdy_o,
    output logic [DWIDTH-1:0]        data_o,
    output logic                     data_val_o,
    output logic                     data_last_o,
    input  logic                     data_rdy_i,
    output logic                     busy_o,
    output logic                     timeout_o
);

    rr_state_e           state_q;
    logic [REQWIDTH-1:0] sel_q;
    logic [DWIDTH-1:0]   sel_data;
    logic                sel_val;
    logic                sel_last;
    logic [1:0]          skid_cnt;
    logic                skid_empty;
    logic                skid_full;
    logic                lane_open;
    logic                accept;
    logic                grant_ok;
    logic                tmo_hit;

    assign lane_open = (state_q == LOCK) && (skid_cnt < 2'd2);
    assign grant_ok  = req_num_val_i && (32'(req_num_i) < REQCNT);

    always_comb begin
        sel_data   = '0;
        sel_val    = 1'b0;
        sel_last   = 1'b0;
        data_rdy_o = '0;
        for (int k = 0; k < REQCNT; k++) begin
            if (sel_q == k[REQWIDTH-1:0]) begin
                sel_data      = data_i[k*DWIDTH +: DWIDTH];
                sel_val       = data_val_i[k];
                sel_last      = data_last_i[k];
                data_rdy_o[k] = lane_open;
            end
        end
    end

    assign accept = lane_open && sel_val;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT) + 1;
    logic [TCW-1:0] tcnt_q;

    // Counts consecutive locked cycles without an accepted beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tcnt_q <= '0;
        end else if ((state_q != LOCK) || accept || tmo_hit) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == LOCK) && (tcnt_q == TCW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ok) begin
                        sel_q   <= req_num_i;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if ((accept && sel_last) || tmo_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    rr_skid_buf #(
        .W (DWIDTH + 1)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (accept && !skid_full),
        .pop_i   (data_val_o && data_rdy_i),
        .din_i   ({sel_last, sel_data}),
        .dout_o  ({data_last_o, data_o}),
        .count_o (skid_cnt),
        .empty_o (skid_empty),
        .full_o  (skid_full)
    );

    assign data_val_o = !skid_empty;
    assign busy_o     = (state_q == LOCK);
    assign timeout_o  = tmo_hit;

endmodule

// File: tb/tb_rr_grant_mux.sv
// Self-checking bench for rr_grant_mux: queue-based reference model plus directed scenarios.
module tb_rr_grant_mux;

    localparam int REQCNT   = 5;
    localparam int REQWIDTH = 3;
    localparam int DWIDTH   = 8;
    localparam int TIMEOUT  = 16;

    logic                     clk_i = 1'b0;
    logic                     rst_n_i;
    logic [REQWIDTH-1:0]      req_num_i;
    logic                     req_num_val_i;
    logic [REQCNT*DWIDTH-1:0] data_i;
    logic [REQCNT-1:0]        data_val_i;
    logic [REQCNT-1:0]        data_last_i;
    logic [REQCNT-1:0]        data_rdy_o;
    logic [DWIDTH-1:0]        data_o;
    logic                     data_val_o;
    logic                     data_last_o;
    logic                     data_rdy_i;
    logic                     busy_o;
    logic                     timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    rr_grant_mux #(
        .REQCNT   (REQCNT),
        .REQWIDTH (REQWIDTH),
        .DWIDTH   (DWIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_num_i     (req_num_i),
        .req_num_val_i (req_num_val_i),
        .data_i        (data_i),
        .data_val_i    (data_val_i),
        .data_last_i   (data_last_i),
        .data_rdy_o    (data_rdy_o),
        .data_o        (data_o),
        .data_val_o    (data_val_o),
        .data_last_o   (data_last_o),
        .data_rdy_i    (data_rdy_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, selected index, FIFO of {last,data}, idle-lock age.
    bit              m_busy;
    int              m_sel;
    logic [8:0]      m_q[$];
    int              m_age;
    logic [4:0]      e_rdy;
    bit              e_tmo;
    bit              m_acc;
    bit              m_pop;
    logic [8:0]      m_beat;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            m_busy = 0; m_sel = 0; m_q.delete(); m_age = 0;
            chk("rst_busy", busy_o, 0);
            chk("rst_rdy", data_rdy_o, 0);
            chk("rst_val", data_val_o, 0);
            chk("rst_last", data_last_o, 0);
            chk("rst_data", data_o, 0);
            chk("rst_tmo", timeout_o, 0);
        end else begin
            e_rdy = '0;
            if (m_busy && m_q.size() < 2) e_rdy[m_sel] = 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
            e_tmo = m_busy && (m_age == TIMEOUT - 1);
`else
            e_tmo = 0;
`endif
            chk("m_busy", busy_o, m_busy);
            chk("m_rdy", data_rdy_o, e_rdy);
            chk("m_val", data_val_o, m_q.size() > 0);
            chk("m_tmo", timeout_o, e_tmo);
            if (m_q.size() > 0) chk("m_head", {data_last_o, data_o}, m_q[0]);
            m_acc  = m_busy && data_val_i[m_sel] && (m_q.size() < 2);
            m_pop  = (m_q.size() > 0) && data_rdy_i;
            m_beat = {data_last_i[m_sel], data_i[m_sel*DWIDTH +: DWIDTH]};
            if (m_pop) void'(m_q.pop_front());
            if (m_acc) m_q.push_back(m_beat);
            if (!m_busy) begin
                m_age = 0;
                if (req_num_val_i && int'(req_num_i) < REQCNT) begin
                    m_busy = 1;
                    m_sel  = int'(req_num_i);
                end
            end else if ((m_acc && m_beat[8]) || e_tmo) begin
                m_busy = 0;
                m_age  = 0;
            end else if (m_acc) begin
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one beat on requester r until accepted; seen = {val,last,data} at first negedge.
    task automatic beat(input int r, input logic [7:0] d, input logic l, output logic [9:0] seen);
        bit got = 0;
        bit first = 1;
        seen = '0;
        data_val_i = '0;
        data_last_i = '0;
        data_val_i[r] = 1'b1;
        data_last_i[r] = l;
        data_i[r*DWIDTH +: DWIDTH] = d;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            if (first) seen = {data_val_o, data_last_o, data_o};
            first = 0;
            got = data_rdy_o[r];
            step();
        end
        data_val_i = '0;
        data_last_i = '0;
        chk("beat_accept", got, 1);
    endtask

    logic [9:0] s;

    initial begin
        rst_n_i = 1'b0; req_num_i = '0; req_num_val_i = 1'b0;
        data_i = '0; data_val_i = '0; data_last_i = '0; data_rdy_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("reset_outputs", {busy_o, timeout_o, data_val_o, data_last_o, data_rdy_o, data_o}, 0);
        step();
        rst_n_i = 1'b1;
        step();

        // Three-beat packet on requester 2, sink always ready.
        data_rdy_i = 1'b1;
        req_num_i = 3'd2; req_num_val_i = 1'b1;
        step();
        req_num_val_i = 1'b0;
        beat(2, 8'hA1, 1'b0, s);
        chk("t1_empty_before", s[9], 0);
        beat(2, 8'hA2, 1'b0, s);
        chk("t1_out_a1", s, 10'h2A1);
        beat(2, 8'hA3, 1'b1, s);
        chk("t1_out_a2", s, 10'h2A2);
        @(negedge clk_i);
        chk("t1_out_a3", {data_val_o, data_last_o, data_o}, 10'h3A3);
        chk("t1_busy_fall", busy_o, 0);
        step();
        step();

        // Back-pressure: ready drops after two accepts, head holds.
        data_rdy_i = 1'b0;
        req_num_i = 3'd1; req_num_val_i = 1'b1;
        step();
        req_num_val_i = 1'b0;
        beat(1, 8'hB1, 1'b0, s);
        beat(1, 8'hB2, 1'b0, s);
        chk("t2_b1_visible", s, 10'h2B1);
        data_val_i[1] = 1'b1;
        data_i[1*DWIDTH +: DWIDTH] = 8'hB3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("t2_rdy_low", data_rdy_o, 0);
            chk("t2_hold_b1", {data_val_o, data_last_o, data_o}, 10'h2B1);
            step();
        end
        data_rdy_i = 1'b1;
        beat(1, 8'hB3, 1'b0, s);
        chk("t2_release_head", s, 10'h2B1);
        beat(1, 8'hB4, 1'b1, s);
        repeat (4) step();

        // Top index, grant during lock ignored, immediate regrant after last.
        req_num_i = 3'd4; req_num_val_i = 1'b1;
        step();
        req_num_i = 3'd1;
        @(negedge clk_i);
        chk("t3_sel4", data_rdy_o, 5'b10000);
        step();
        req_num_val_i = 1'b0;
        beat(4, 8'hC1, 1'b0, s);
        beat(4, 8'hC2, 1'b1, s);
        req_num_i = 3'd0; req_num_val_i = 1'b1;
        @(negedge clk_i);
        chk("t3_dead_cycle", busy_o, 0);
        step();
        req_num_val_i = 1'b0;
        @(negedge clk_i);
        chk("t3_sel0", {busy_o, data_rdy_o}, 6'b100001);
        step();
        beat(0, 8'hD1, 1'b1, s);
        repeat (3) step();

        // Out-of-range grant index.
        req_num_i = 3'd7; req_num_val_i = 1'b1; data_val_i = '1;
        step();
        req_num_val_i = 1'b0;
        @(negedge clk_i);
        chk("t4_no_lock", {busy_o, data_rdy_o, data_val_o}, 0);
        step();
        data_val_i = '0;
        step();

        // Reset in the middle of a packet.
        data_rdy_i = 1'b0;
        req_num_i = 3'd3; req_num_val_i = 1'b1;
        step();
        req_num_val_i = 1'b0;
        beat(3, 8'hE1, 1'b0, s);
        beat(3, 8'hE2, 1'b0, s);
        rst_n_i = 1'b0;
        #1;
        chk("t5_async_clear", {busy_o, timeout_o, data_val_o, data_last_o, data_rdy_o, data_o}, 0);
        step();
        rst_n_i = 1'b1;
        data_rdy_i = 1'b1;
        data_val_i[3] = 1'b1;
        data_i[3*DWIDTH +: DWIDTH] = 8'hE3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t5_ignored", {busy_o, data_rdy_o, data_val_o}, 0);
            step();
        end
        data_val_i = '0;
        step();

        // Lock with no traffic.
        req_num_i = 3'd0; req_num_val_i = 1'b1;
        step();
        req_num_val_i = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk_i);
            chk("t6_tmo_pulse", timeout_o, (k == TIMEOUT));
            step();
        end
        @(negedge clk_i);
        chk("t6_busy_after_tmo", {busy_o, timeout_o}, 0);
        step();
`else
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            @(negedge clk_i);
            chk("t6_lock_held", {busy_o, timeout_o}, 2'b10);
            step();
        end
        beat(0, 8'hF1, 1'b1, s);
        @(negedge clk_i);
        chk("t6_unlock", busy_o, 0);
        step();
`endif
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_mux.md
RR_GRANT_MUX -- requirements
Module: rr_grant_mux

Interface
REQ-001 Parameter REQCNT, default 5: number of requesters.
REQ-002 Parameter REQWIDTH, default $clog2(REQCNT): grant index width.
REQ-003 Parameter DWIDTH, default 8: data beat width.
REQ-004 Parameter TIMEOUT, default 16: idle-lock limit in cycles, used only under RR_GRANT_TIMEOUT_EN.
REQ-005 clk_i  in  1  single clock; all logic on posedge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 req_num_i  in  REQWIDTH  granted requester index from arbiter.
REQ-008 req_num_val_i  in  1  grant index valid.
REQ-009 data_i  in  REQCNT*DWIDTH  requester k beat at [k*DWIDTH +: DWIDTH].
REQ-010 data_val_i  in  REQCNT  per-requester beat valid.
REQ-011 data_last_i  in  REQCNT  per-requester end-of-packet flag.
REQ-012 data_rdy_o  out  REQCNT  per-requester accept, at most one bit set.
REQ-013 data_o  out  DWIDTH  muxed beat.
REQ-014 data_val_o / data_last_o  out  1 each  beat valid / end of packet.
REQ-015 data_rdy_i  in  1  downstream accept.
REQ-016 busy_o  out  1  high while a grant is locked.
REQ-017 timeout_o  out  1  one-cycle lock-abort pulse.

Function
REQ-018 FSM states IDLE, LOCK; busy_o = (state == LOCK).
REQ-019 IDLE: req_num_val_i=1 and req_num_i<REQCNT latches sel<=req_num_i, next state LOCK; req_num_i>=REQCNT ignored, stay IDLE.
REQ-020 Grants presented during LOCK are ignored; no queuing.
REQ-021 data_rdy_o all zero in IDLE; in LOCK only bit sel set, equal to (skid count < 2), from registered count.
REQ-022 Beat accepted when data_val_i[sel] && data_rdy_o[sel]; {data, last} pushed into 2-entry skid buffer.
REQ-023 data_val_o = skid non-empty; data_o/data_last_o = skid head; pop when data_val_o && data_rdy_i.
REQ-024 Latency: beat accepted at cycle N, skid empty -> data_val_o high at cycle N+1.
REQ-025 Count 2 with pop in same cycle: no push that cycle (ready already low).
REQ-026 data_o, data_last_o stable while data_val_o=1 and data_rdy_i=0.
REQ-027 Accepted beat with last=1 -> LOCK->IDLE next cycle; new grant accepted in that IDLE cycle, so min one dead cycle between packets.
REQ-028 Skid keeps draining in IDLE and across a new lock; beat order preserved.
REQ-029 Index REQCNT-1 is valid; no wrap logic on sel.

Reset
REQ-030 rst_n_i low: state IDLE, sel 0, skid empty, timeout counter 0; data_rdy_o, data_val_o, data_last_o, data_o, busy_o, timeout_o all 0.
REQ-031 Reset mid-packet discards skid contents and lock; following beats are ignored until a new grant.

Configuration
REQ-032 Macro RR_GRANT_TIMEOUT_EN defined: counter increments each LOCK cycle with no accepted beat, clears on accept or IDLE; reaching TIMEOUT-1 forces IDLE next cycle and pulses timeout_o one cycle; skid content kept, no synthetic last.
REQ-033 Macro undefined: no counter, timeout_o tied 0, lock held until last.

Structure
REQ-034 Package rr_pkg holds the FSM state typedef (IDLE, LOCK) and default REQCNT/DWIDTH constants.
REQ-035 Sub-module rr_skid_buf: 2-entry {data,last} buffer with push/pop, count, empty/full.

Verification
REQ-036 Grant 2, requester 2 sends 3 beats (0xA1,0xA2,0xA3 last), data_rdy_i=1 -> outputs same order, each 1 cycle after accept, busy_o falls cycle after last accept.
REQ-037 data_rdy_i=0 during 4-beat packet -> data_rdy_o[sel] drops after 2 accepts, data_o holds 1st beat, no loss after release.
REQ-038 Grant 4 (REQCNT-1) then grant 0 right after last -> both packets complete, one dead cycle, grant during LOCK ignored.
REQ-039 req_num_i=7 with valid (REQCNT=5) -> stays IDLE, data_rdy_o=0.
REQ-040 rst_n_i low mid-packet -> all outputs 0 immediately; post-reset beats ignored.
REQ-041 RR_GRANT_TIMEOUT_EN, TIMEOUT=16, lock with no valid beats -> timeout_o pulse at 16th LOCK cycle, busy_o 0 next cycle.
